div_unit: RTL and testbench
===========================

Name: div_unit

Overview:
- Multi-cycle 32-bit integer divider for DIV/DIVU.
- Sits beside the CPU top level: consumes the top's div_op1/div_op2/div_start/div_sign outputs and returns div_result/div_final to the EX stage.
- EX holds start high and stalls the pipeline until final is seen, then drops start.
- Radix-2 restoring algorithm on operand magnitudes, with sign fix-up at the end.

Parameters:
- WIDTH, 32, operand width; the result is 2*WIDTH bits.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- div_op1_i  in  WIDTH  dividend
- div_op2_i  in  WIDTH  divisor
- div_start_i  in  1  request; held high by EX until div_final_o is seen
- div_sign_i  in  1  1 = signed (DIV), 0 = unsigned (DIVU)
- div_annul_i  in  1  abort current operation (flush/exception)
- div_result_o  out  2*WIDTH  [63:32] = remainder (HI), [31:0] = quotient (LO)
- div_final_o  out  1  result valid

Behaviour:
- Clock/reset: one clock, clk. Reset rst is asynchronous and active-high. On reset: state=IDLE, count=0, div_result_o=0, div_final_o=0, all internal registers 0.
- States: IDLE, BYZERO, ON, END.
- IDLE, transitions on the edge where div_start_i=1 and div_annul_i=0:
  - div_op2_i==0 -> go to BYZERO.
  - Otherwise -> go to ON. On that edge: latch sign; latch |op1| and |op2| (two's-complement negate only when sign=1 and the MSB is set); latch raw op1[31] and op2[31]; clear the partial remainder; count=0.
- IDLE, no transition: start=0 or annul=1 -> stay in IDLE, outputs 0.
- BYZERO: next edge -> END with result 64'h0.
  - Divide-by-zero is architecturally undefined; zero is our decided value.
- ON, one restoring step per cycle:
  - Form {rem, dvd} shifted left by 1.
  - If shifted rem >= |divisor|: rem -= |divisor| and the quotient LSB = 1; else quotient LSB = 0.
  - count increments each step. After the step with count==WIDTH-1 -> END.
- END entry, sign fix-up:
  - If sign=1 and op1[31]^op2[31]: negate the quotient.
  - If sign=1 and op1[31]: negate the remainder.
  - Register the result; div_final_o=1.
- END:
  - Holds div_result_o and div_final_o while div_start_i=1.
  - When div_start_i=0 -> IDLE; div_final_o=0 and div_result_o=0 on that same edge.
- Latency (start sampled at edge k):
  - Normal: final visible after edge k+WIDTH+1 (k+33).
  - Divide-by-zero: final visible after edge k+2.
- Annul:
  - div_annul_i=1 in BYZERO or ON -> IDLE on the next edge; no final is ever produced for that operation.
  - Annul in END -> IDLE, outputs cleared.
  - Annul has priority over every other transition.
- Operands and sign are sampled only in IDLE; input changes during BYZERO/ON/END are ignored.
- Overflow case 0x80000000 / 0xFFFFFFFF signed: quotient 0x80000000, remainder 0. No trap is raised.
- Back-to-back operations: a new start is accepted only from IDLE. At least one idle cycle with start=0 is therefore required between operations.
- Async reset mid-operation: immediate return to IDLE, outputs 0.

Optional Feature:
- DIV_EARLY_TERM_EN defined:
  - In the first ON cycle (count==0), if |dividend| < |divisor|, go directly to END.
  - Quotient = 0, remainder = the latched dividend magnitude; normal sign fix-up applies.
  - Final is visible after edge k+2.
- DIV_EARLY_TERM_EN undefined: every nonzero-divisor operation takes the full WIDTH steps.

Test Plan:
- Unsigned 100 / 7, start at edge k, hold start -> div_final_o rises after edge k+33. div_result_o = {32'd2, 32'd14}. Start dropped -> final=0, result=0 on the next edge.
- Signed 0xFFFFFFF9 (-7) / 2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Signed 7 / 0xFFFFFFFE -> quotient 0xFFFFFFFD, remainder 0x00000001.
- Divisor 0 (either sign mode), start at edge k -> final after edge k+2, result 64'h0.
- Start 0xFFFFFFFF / 3 unsigned, pulse annul at the 10th ON cycle:
  - Required: IDLE next edge, final never rises.
  - Then start 9 / 3 -> {0, 3} after 33 cycles.
- Signed 0x80000000 / 0xFFFFFFFF -> result {32'h0, 32'h80000000}. Assert rst asynchronously mid-ON -> outputs 0 immediately, without waiting for a clock edge.
- Unsigned 5 / 9:
  - With DIV_EARLY_TERM_EN -> final after edge k+2, result {32'd5, 32'd0}.
  - Without DIV_EARLY_TERM_EN -> same result after edge k+33.

Source files
------------

// File: rtl/div_unit_if.sv
// Handshake bundle between the CPU top level (master) and the multi-cycle divider (slave).
interface div_unit_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0]   div_op1_i;
  logic [WIDTH-1:0]   div_op2_i;
  logic               div_start_i;
  logic               div_sign_i;
  logic               div_annul_i;
  logic [2*WIDTH-1:0] div_result_o;
  logic               div_final_o;

  modport master (
    output div_op1_i, div_op2_i, div_start_i, div_sign_i, div_annul_i,
    input  div_result_o, div_final_o
  );

  modport slave (
    input  div_op1_i, div_op2_i, div_start_i, div_sign_i, div_annul_i,
    output div_result_o, div_final_o
  );
endinterface

// File: rtl/div_unit.sv
// Radix-2 restoring divider for DIV/DIVU: magnitudes in, sign fix-up on END entry.
// Optional macro DIV_EARLY_TERM_EN: skip the iteration when |dividend| < |divisor|.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       rst,
  div_unit_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_BYZERO = 2'd1;
  localparam logic [1:0] S_ON     = 2'd2;
  localparam logic [1:0] S_END    = 2'd3;

  logic [1:0]         r_state;
  logic [CW-1:0]      r_count;
  logic               r_sign;
  logic               r_op1_msb;
  logic               r_op2_msb;
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_dvd;   // dividend magnitude, shifts into the quotient
  logic [WIDTH-1:0]   r_dsr;
  logic [2*WIDTH-1:0] r_result;
  logic               r_final;

  logic               w_start;
  logic [WIDTH-1:0]   w_abs1;
  logic [WIDTH-1:0]   w_abs2;
  logic [WIDTH:0]     w_rem_sh;
  logic [WIDTH:0]     w_diff;
  logic               w_ge;
  logic [WIDTH-1:0]   w_rem_nx;
  logic [WIDTH-1:0]   w_quo_nx;
  logic [WIDTH-1:0]   w_quo_fix;
  logic [WIDTH-1:0]   w_rem_fix;
  logic               w_early;

  assign w_start = bus.div_start_i && !bus.div_annul_i;
  assign w_abs1  = (bus.div_sign_i && bus.div_op1_i[WIDTH-1]) ? -bus.div_op1_i : bus.div_op1_i;
  assign w_abs2  = (bus.div_sign_i && bus.div_op2_i[WIDTH-1]) ? -bus.div_op2_i : bus.div_op2_i;

  // rem < divisor always holds, so the shifted remainder minus divisor fits in
  // WIDTH+1 bits and its top bit is the borrow.
  assign w_rem_sh = {r_rem, r_dvd[WIDTH-1]};
  assign w_diff   = w_rem_sh - {1'b0, r_dsr};
  assign w_ge     = ~w_diff[WIDTH];
  assign w_rem_nx = w_ge ? w_diff[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
  assign w_quo_nx = {r_dvd[WIDTH-2:0], w_ge};

  assign w_quo_fix = (r_sign && (r_op1_msb ^ r_op2_msb)) ? -r_dvd : r_dvd;
  assign w_rem_fix = (r_sign && r_op1_msb) ? -r_rem : r_rem;

`ifdef DIV_EARLY_TERM_EN
  assign w_early = (r_count == '0) && (r_dvd < r_dsr);
`else
  assign w_early = 1'b0;
`endif

  // NOTE: datapath registers are reset along with the control state so an
  // aborted operation can never leak stale magnitudes into the next one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_count   <= '0;
      r_sign    <= 1'b0;
      r_op1_msb <= 1'b0;
      r_op2_msb <= 1'b0;
      r_rem     <= '0;
      r_dvd     <= '0;
      r_dsr     <= '0;
      r_result  <= '0;
      r_final   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch reads the
      // pre-edge register values regardless of statement order.
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_count <= '0;
            r_rem   <= '0;
            if (bus.div_op2_i == '0) begin
              r_state   <= S_BYZERO;
              r_sign    <= 1'b0;
              r_op1_msb <= 1'b0;
              r_op2_msb <= 1'b0;
              r_dvd     <= '0;
              r_dsr     <= '0;
            end else begin
              r_state   <= S_ON;
              r_sign    <= bus.div_sign_i;
              r_op1_msb <= bus.div_op1_i[WIDTH-1];
              r_op2_msb <= bus.div_op2_i[WIDTH-1];
              r_dvd     <= w_abs1;
              r_dsr     <= w_abs2;
            end
          end
        end

        S_BYZERO: begin
          r_state <= bus.div_annul_i ? S_IDLE : S_END;
        end

        S_ON: begin
          if (bus.div_annul_i) begin
            r_state <= S_IDLE;
          end else if (w_early) begin
            r_state <= S_END;
            r_rem   <= r_dvd;
            r_dvd   <= '0;
          end else begin
            r_rem   <= w_rem_nx;
            r_dvd   <= w_quo_nx;
            r_count <= r_count + CW'(1);
            if (r_count == CW'(WIDTH - 1)) r_state <= S_END;
          end
        end

        S_END: begin
          if (bus.div_annul_i || !bus.div_start_i) begin
            r_state  <= S_IDLE;
            r_result <= '0;
            r_final  <= 1'b0;
          end else if (!r_final) begin
            r_result <= {w_rem_fix, w_quo_fix};
            r_final  <= 1'b1;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.div_result_o = r_result;
  assign bus.div_final_o  = r_final;
endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: stimulus pushes expected result and arrival cycle,
// a negedge monitor pops and compares on every rising div_final_o.
module tb_div_unit;
  localparam int W = 32;

  typedef struct {
    logic [2*W-1:0] res;
    int             cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  logic prev_final = 1'b0;
  exp_t sb[$];

  div_unit_if #(.WIDTH(W)) bus ();

  div_unit #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every rising final must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && bus.div_final_o && !prev_final) begin
      if (sb.size() == 0) begin
        check("unexpected_final", {{(2*W-1){1'b0}}, bus.div_final_o}, '0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("result", bus.div_result_o, e.res);
        check("latency_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
    prev_final = bus.div_final_o;
  end

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                       input logic [2*W-1:0] exp_res, input int lat);
    bit done = 1'b0;
    @(negedge clk);
    bus.div_op1_i   = a;
    bus.div_op2_i   = b;
    bus.div_sign_i  = s;
    bus.div_start_i = 1'b1;
    sb.push_back('{exp_res, cyc + 1 + lat});
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (bus.div_final_o) done = 1'b1;
    end
    if (!done) check("timeout_final", {{(2*W-1){1'b0}}, bus.div_final_o}, 64'd1);
  endtask

  task automatic finish_op(input logic [2*W-1:0] exp_res);
    // Scramble inputs: they must be ignored outside IDLE.
    bus.div_op1_i = 32'hDEAD_BEEF;
    bus.div_op2_i = 32'h0000_0000;
    @(negedge clk);
    check("hold_result", bus.div_result_o, exp_res);
    check("hold_final", {63'b0, bus.div_final_o}, 64'd1);
    bus.div_start_i = 1'b0;
    @(negedge clk);
    check("drop_final", {63'b0, bus.div_final_o}, 64'd0);
    check("drop_result", bus.div_result_o, 64'd0);
    @(negedge clk);
  endtask

  task automatic run(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                     input logic [2*W-1:0] exp_res, input int lat);
    issue(a, b, s, exp_res, lat);
    finish_op(exp_res);
  endtask

  initial begin
    bus.div_op1_i   = '0;
    bus.div_op2_i   = '0;
    bus.div_start_i = 1'b0;
    bus.div_sign_i  = 1'b0;
    bus.div_annul_i = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_result", bus.div_result_o, 64'd0);
    check("reset_final", {63'b0, bus.div_final_o}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    run(32'd100, 32'd7, 1'b0, {32'd2, 32'd14}, 33);
    run(32'hFFFF_FFF9, 32'd2, 1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33);
    run(32'd7, 32'hFFFF_FFFE, 1'b1, {32'h0000_0001, 32'hFFFF_FFFD}, 33);
    run(32'd5, 32'd0, 1'b0, 64'd0, 2);
    run(32'hFFFF_FFF9, 32'd0, 1'b1, 64'd0, 2);

    // Annul on the 10th ON cycle: no final may ever appear for this op.
    @(negedge clk);
    bus.div_op1_i   = 32'hFFFF_FFFF;
    bus.div_op2_i   = 32'd3;
    bus.div_sign_i  = 1'b0;
    bus.div_start_i = 1'b1;
    repeat (10) @(negedge clk);
    bus.div_annul_i = 1'b1;
    @(negedge clk);
    bus.div_annul_i = 1'b0;
    bus.div_start_i = 1'b0;
    check("annul_final", {63'b0, bus.div_final_o}, 64'd0);
    repeat (40) @(negedge clk);
    run(32'd9, 32'd3, 1'b0, {32'd0, 32'd3}, 33);

`ifdef DIV_EARLY_TERM_EN
    run(32'd5, 32'd9, 1'b0, {32'd5, 32'd0}, 2);
`else
    run(32'd5, 32'd9, 1'b0, {32'd5, 32'd0}, 33);
`endif

    // Annul while the result is being held.
    issue(32'd100, 32'd7, 1'b0, {32'd2, 32'd14}, 33);
    bus.div_annul_i = 1'b1;
    @(negedge clk);
    check("annul_end_final", {63'b0, bus.div_final_o}, 64'd0);
    check("annul_end_result", bus.div_result_o, 64'd0);
    bus.div_annul_i = 1'b0;
    bus.div_start_i = 1'b0;
    @(negedge clk);

    // Overflow case, then async reset while the result is held.
    issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, {32'h0, 32'h8000_0000}, 33);
    #2 rst = 1'b1;
    #1;
    check("async_rst_final", {63'b0, bus.div_final_o}, 64'd0);
    check("async_rst_result", bus.div_result_o, 64'd0);
    bus.div_start_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Async reset mid-ON: the aborted op must never complete.
    bus.div_op1_i   = 32'hFFFF_FFFF;
    bus.div_op2_i   = 32'd3;
    bus.div_sign_i  = 1'b0;
    bus.div_start_i = 1'b1;
    repeat (6) @(negedge clk);
    #2 rst = 1'b1;
    bus.div_start_i = 1'b0;
    #1;
    check("rst_mid_on_final", {63'b0, bus.div_final_o}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    run(32'd100, 32'd7, 1'b0, {32'd2, 32'd14}, 33);

    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
